// File: rtl/audio_mix_pkg.sv
// ---------------------------------------------------------------------------
// audio_mix_pkg
// Shared types and helpers for the dual OPL audio mixer and its output FIFO.
//   sample_t  : signed 16-bit audio sample
//   SAT_MAX / SAT_MIN : saturation rails for a 16-bit sample
//   sat_t     : saturated value plus a flag telling whether clamping occurred
//   sat16()   : clamps a signed 22-bit intermediate mix to the 16-bit range
// ---------------------------------------------------------------------------
package audio_mix_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  // Rails expressed at the width of the pre-saturation mix.
  localparam logic signed [21:0] MIX_HI = 22'sd32767;
  localparam logic signed [21:0] MIX_LO = -22'sd32768;

  typedef struct packed {
    logic    clip;
    sample_t value;
  } sat_t;

  function automatic sat_t sat16(input logic signed [21:0] v);
    sat_t r;
    if (v > MIX_HI) begin
      r.clip  = 1'b1;
      r.value = SAT_MAX;
    end else if (v < MIX_LO) begin
      r.clip  = 1'b1;
      r.value = SAT_MIN;
    end else begin
      r.clip  = 1'b0;
      r.value = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous FIFO with a registered head word. Data written into an empty
// FIFO becomes visible on head/valid one clock after the push; nothing
// bypasses the storage path combinationally.
// Parameters: WIDTH data width, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst    clock and synchronous active-high reset (empties the FIFO)
//   push        write push_data this cycle (ignored when full unless popping)
//   push_data   word to write
//   pop         consume the head this cycle (ignored when empty)
//   head        registered head word, holds while not popped
//   valid       registered "FIFO not empty"
//   full, empty status decoded from the pointers
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [AW:0]      wptr_n;
  logic [AW:0]      rptr_n;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_n;
  logic             valid_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic             next_empty_s;

  // Pointer status and next-state computation, including the next head word.
  always_comb begin
    empty     = (wptr_r == rptr_r);
    full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    do_pop_s  = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees a slot.
    do_push_s = push & (~full | do_pop_s);
    wptr_n    = do_push_s ? (wptr_r + PTR_ONE) : wptr_r;
    rptr_n    = do_pop_s  ? (rptr_r + PTR_ONE) : rptr_r;
    next_empty_s = (wptr_n == rptr_n);
    if (next_empty_s) begin
      head_n = head_r;
    end else if (do_push_s && (rptr_n[AW-1:0] == wptr_r[AW-1:0])) begin
      // The word becoming head is the one being written this cycle.
      head_n = push_data;
    end else begin
      head_n = mem_r[rptr_n[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r[AW-1:0]] <= push_data;
    end
  end

  // Pointers, registered head and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      head_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      wptr_r  <= wptr_n;
      rptr_r  <= rptr_n;
      head_r  <= head_n;
      valid_r <= ~next_empty_s;
    end
  end

  assign head  = head_r;
  assign valid = valid_r;

endmodule

// File: rtl/dual_opl_audio_mixer.sv
// ---------------------------------------------------------------------------
// dual_opl_audio_mixer
// Mixes the two YM3526 outputs: per-chip gain (units of 1/4), sum with
// saturation, optional one-pole low-pass, then an output FIFO drained by the
// audio serializer with valid/ready.
// Pipeline: S1 gain products -> S2 sum/shift/saturate/mute -> S3 LPF ->
// FIFO push. The first sample is on out_valid 4 clocks after its strobe.
// Parameters: LPF_SHIFT (1..6) low-pass coefficient 2^-LPF_SHIFT,
//             FIFO_DEPTH (power of 2, 2..16) output FIFO entries.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   sample          one-clock strobe qualifying snd1/snd2
//   snd1, snd2      signed chip outputs
//   gain1, gain2    unsigned gains, 1/4 steps
//   mute            forces the mixed value to 0 (filter keeps running)
//   lpf_en          select filtered (1) or raw saturated mix (0)
//   clr_flags       clears clip/overrun (wins over a same-cycle set)
//   out_data        FIFO head, signed
//   out_valid       FIFO not empty
//   out_ready       consumer accepts head on out_valid & out_ready
//   clip            sticky saturation flag
//   overrun         sticky dropped-sample flag
// ---------------------------------------------------------------------------
module dual_opl_audio_mixer
  import audio_mix_pkg::*;
#(
  parameter int LPF_SHIFT  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [15:0] snd1,
  input  logic [15:0] snd2,
  input  logic [3:0]  gain1,
  input  logic [3:0]  gain2,
  input  logic        mute,
  input  logic        lpf_en,
  input  logic        clr_flags,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        clip,
  output logic        overrun
);

  localparam int ACC_W = 16 + LPF_SHIFT;

  // S1 state
  logic                    v1_r;
  logic signed [20:0]      p1_r;
  logic signed [20:0]      p2_r;
  logic                    mute1_r;
  logic                    lpf1_r;
  logic signed [20:0]      p1_s;
  logic signed [20:0]      p2_s;

  // S2 state
  logic                    v2_r;
  sample_t                 x2_r;
  logic                    lpf2_r;
  logic signed [21:0]      sum_s;
  logic signed [21:0]      shift_s;
  sat_t                    sat_s;
  sample_t                 x_s;
  logic                    clip_set_s;

  // S3 state
  logic                    v3_r;
  sample_t                 y3_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W:0]   diff_s;
  logic signed [ACC_W:0]   step_s;
  logic signed [ACC_W-1:0] acc_n_s;
  sample_t                 y_s;

  // Output side
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    pop_s;
  logic                    ovr_set_s;
  logic                    clip_r;
  logic                    overrun_r;

  // S1 products: signed sample times zero-extended (non-negative) gain.
  always_comb begin
    p1_s = $signed({{5{snd1[15]}}, snd1}) * $signed({17'd0, gain1});
    p2_s = $signed({{5{snd2[15]}}, snd2}) * $signed({17'd0, gain2});
  end

  // S1 registers: products and the per-sample controls travel together.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      p1_r    <= 21'sd0;
      p2_r    <= 21'sd0;
      mute1_r <= 1'b0;
      lpf1_r  <= 1'b0;
    end else begin
      v1_r <= sample;
      if (sample) begin
        p1_r    <= p1_s;
        p2_r    <= p2_s;
        mute1_r <= mute;
        lpf1_r  <= lpf_en;
      end else begin
        p1_r    <= p1_r;
        p2_r    <= p2_r;
        mute1_r <= mute1_r;
        lpf1_r  <= lpf1_r;
      end
    end
  end

  // S2 sum, divide by 4 (gain units), saturate; mute suppresses value and clip.
  always_comb begin
    sum_s   = {p1_r[20], p1_r} + {p2_r[20], p2_r};
    shift_s = sum_s >>> 2;
    sat_s   = sat16(shift_s);
    if (mute1_r) begin
      x_s = 16'sd0;
    end else begin
      x_s = sat_s.value;
    end
    clip_set_s = v1_r & ~mute1_r & sat_s.clip;
  end

  // S2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r   <= 1'b0;
      x2_r   <= 16'sd0;
      lpf2_r <= 1'b0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        x2_r   <= x_s;
        lpf2_r <= lpf1_r;
      end else begin
        x2_r   <= x2_r;
        lpf2_r <= lpf2_r;
      end
    end
  end

  // S3 one-pole low-pass: acc += (x*2^k - acc) >>> k. The difference gets
  // one guard bit; the step always moves acc toward the target so the sum
  // stays within ACC_W bits.
  always_comb begin
    diff_s  = $signed({x2_r[15], x2_r, {LPF_SHIFT{1'b0}}}) - $signed({acc_r[ACC_W-1], acc_r});
    step_s  = diff_s >>> LPF_SHIFT;
    acc_n_s = acc_r + step_s[ACC_W-1:0];
    y_s     = lpf2_r ? acc_n_s[ACC_W-1 -: 16] : x2_r;
  end

  // S3 registers: the accumulator advances on every valid sample, whether or
  // not the filtered value is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r  <= 1'b0;
      y3_r  <= 16'sd0;
      acc_r <= '0;
    end else begin
      v3_r <= v2_r;
      if (v2_r) begin
        y3_r  <= y_s;
        acc_r <= acc_n_s;
      end else begin
        y3_r  <= y3_r;
        acc_r <= acc_r;
      end
    end
  end

  // Pop decode and overrun detection (full, pushing, no pop to free a slot).
  always_comb begin
    pop_s     = out_ready & ~fifo_empty_s;
    ovr_set_s = v3_r & fifo_full_s & ~pop_s;
  end

  audio_sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (v3_r),
    .push_data (y3_r),
    .pop       (pop_s),
    .head      (out_data),
    .valid     (out_valid),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Sticky flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else if (clr_flags) begin
      clip_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      clip_r    <= clip_r | clip_set_s;
      overrun_r <= overrun_r | ovr_set_s;
    end
  end

  assign clip    = clip_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_dual_opl_audio_mixer.sv
// ---------------------------------------------------------------------------
// tb_dual_opl_audio_mixer
// Randomized and directed stimulus against a behavioural reference: the mix
// is computed with integer arithmetic, the filter with an integer
// accumulator, latency with due-cycle queues and the FIFO with a queue.
// ---------------------------------------------------------------------------
module tb_dual_opl_audio_mixer;

  localparam int LSH   = 3;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample;
  logic [15:0]        snd1;
  logic [15:0]        snd2;
  logic [3:0]         gain1;
  logic [3:0]         gain2;
  logic               mute;
  logic               lpf_en;
  logic               clr_flags;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               clip;
  logic               overrun;

  dual_opl_audio_mixer #(
    .LPF_SHIFT  (LSH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .snd1      (snd1),
    .snd2      (snd2),
    .gain1     (gain1),
    .gain2     (gain2),
    .mute      (mute),
    .lpf_en    (lpf_en),
    .clr_flags (clr_flags),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clip      (clip),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model state
  typedef struct {
    int due;
    int val;
  } item_t;
  item_t push_q[$];
  int    clip_q[$];
  int    fifo_q[$];
  int    m_acc;
  bit    m_valid;
  bit    m_clip;
  bit    m_ov;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mix_ref(input int a, input int b, input int g1, input int g2,
                                 output bit clipped);
    int s;
    s = (a * g1 + b * g2) >>> 2;
    clipped = 1'b0;
    if (s > 32767) begin
      s = 32767;
      clipped = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      clipped = 1'b1;
    end
    return s;
  endfunction

  // Advance the reference by one rising edge using the inputs applied to it.
  task automatic model_edge();
    bit pop, push, full, set_clip, set_ov, c;
    int pv, x, y;
    if (rst) begin
      push_q.delete();
      clip_q.delete();
      fifo_q.delete();
      m_acc = 0; m_valid = 1'b0; m_clip = 1'b0; m_ov = 1'b0;
      return;
    end
    pop = m_valid && out_ready;
    push = 1'b0;
    pv = 0;
    if (push_q.size() > 0 && push_q[0].due == edge_n) begin
      push = 1'b1;
      pv = push_q[0].val;
      void'(push_q.pop_front());
    end
    set_clip = 1'b0;
    if (clip_q.size() > 0 && clip_q[0] == edge_n) begin
      set_clip = 1'b1;
      void'(clip_q.pop_front());
    end
    full = (fifo_q.size() == DEPTH);
    set_ov = push && full && !pop;
    if (pop) void'(fifo_q.pop_front());
    if (push && !set_ov) fifo_q.push_back(pv);
    m_valid = (fifo_q.size() > 0);
    m_clip = clr_flags ? 1'b0 : (m_clip | set_clip);
    m_ov   = clr_flags ? 1'b0 : (m_ov | set_ov);
    if (sample) begin
      x = mix_ref($signed(snd1), $signed(snd2), int'(gain1), int'(gain2), c);
      if (mute) begin
        x = 0;
        c = 1'b0;
      end
      if (c) clip_q.push_back(edge_n + 1);
      m_acc = m_acc + ((x * (1 << LSH) - m_acc) >>> LSH);
      y = lpf_en ? (m_acc >>> LSH) : x;
      push_q.push_back('{edge_n + 3, y});
    end
  endtask

  // One clock: model follows the edge, then every output is compared.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_eq("valid", int'(out_valid), int'(m_valid));
    if (m_valid) check_eq("data", int'(out_data), fifo_q[0]);
    check_eq("clip", int'(clip), int'(m_clip));
    check_eq("overrun", int'(overrun), int'(m_ov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int a, input int b, input int g1, input int g2,
                      input bit m, input bit l);
    snd1 = 16'(a); snd2 = 16'(b); gain1 = 4'(g1); gain2 = 4'(g2);
    mute = m; lpf_en = l; sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int obs_q[$];
  int vals[6];
  int viol;

  initial begin
    rst = 1'b1; sample = 1'b0; snd1 = 16'd0; snd2 = 16'd0; gain1 = 4'd0; gain2 = 4'd0;
    mute = 1'b0; lpf_en = 1'b0; clr_flags = 1'b0; out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_data", int'(out_data), 0);
    check_eq("rst_clip", int'(clip), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Unity mix and latency
    send(1000, -300, 4, 4, 1'b0, 1'b0);
    idle(2);
    check_eq("unity_early", int'(out_valid), 0);
    tick();
    check_eq("unity_valid", int'(out_valid), 1);
    check_eq("unity_data", int'(out_data), 700);

    // Saturation both rails, then clear
    send(20000, 20000, 15, 15, 1'b0, 1'b0);
    idle(3);
    check_eq("sat_pos", int'(out_data), 32767);
    check_eq("sat_clip", int'(clip), 1);
    send(-20000, -20000, 15, 15, 1'b0, 1'b0);
    idle(3);
    check_eq("sat_neg", int'(out_data), -32768);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("clr_clip", int'(clip), 0);

    // LPF step response from a cleared accumulator
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 22; i++) begin
      if (i < 16) send(8000, 0, 4, 0, 1'b0, 1'b1);
      else tick();
      if (out_valid) obs_q.push_back(int'(out_data));
    end
    check_eq("lpf_count", obs_q.size(), 16);
    if (obs_q.size() >= 3) begin
      check_eq("lpf_0", obs_q[0], 1000);
      check_eq("lpf_1", obs_q[1], 1875);
      check_eq("lpf_2", obs_q[2], 2640);
    end
    viol = 0;
    for (int i = 1; i < obs_q.size(); i++) begin
      if (obs_q[i] < obs_q[i-1] || obs_q[i] > 8000) viol++;
    end
    check_eq("lpf_mono", viol, 0);

    // Overrun: five strobes into a stalled FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) vals[i] = int'($urandom_range(0, 1000)) + i * 2000 - 5000;
    for (int i = 0; i < 5; i++) send(vals[i], 0, 4, 0, 1'b0, 1'b0);
    idle(4);
    check_eq("ovr_flag", int'(overrun), 1);
    check_eq("ovr_head", int'(out_data), vals[0]);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check_eq("ovr_clr", int'(overrun), 0);
    // Push while full with a pop in the same cycle
    send(vals[5], 0, 4, 0, 1'b0, 1'b0);
    idle(2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("full_pop_no_ovr", int'(overrun), 0);
    out_ready = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      if (out_valid) obs_q.push_back(int'(out_data));
      tick();
    end
    check_eq("drain_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check_eq("drain_0", obs_q[0], vals[1]);
      check_eq("drain_1", obs_q[1], vals[2]);
      check_eq("drain_2", obs_q[2], vals[3]);
      check_eq("drain_3", obs_q[3], vals[5]);
    end

    // Mute
    send(32767, 32767, 15, 15, 1'b1, 1'b0);
    idle(3);
    check_eq("mute_valid", int'(out_valid), 1);
    check_eq("mute_data", int'(out_data), 0);
    check_eq("mute_clip", int'(clip), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      snd1 = 16'($urandom); snd2 = 16'($urandom);
      gain1 = 4'($urandom); gain2 = 4'($urandom);
      mute = ($urandom_range(0, 7) == 0);
      lpf_en = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      sample = 1'($urandom);
      tick();
    end
    sample = 1'b0; clr_flags = 1'b0; out_ready = 1'b1;
    idle(10);

    // Reset mid-stream with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(100 * (i + 1), 0, 4, 0, 1'b0, 1'b0);
    idle(4);
    check_eq("mid_queued", int'(out_valid), 1);
    do_reset();
    check_eq("mid_rst_valid", int'(out_valid), 0);
    check_eq("mid_rst_data", int'(out_data), 0);
    out_ready = 1'b1;
    send(8000, 0, 4, 0, 1'b0, 1'b1);
    idle(3);
    check_eq("post_rst_valid", int'(out_valid), 1);
    check_eq("post_rst_lpf", int'(out_data), 1000);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
